assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 30, word-address width.
REQ-003 SHALL have parameter SET_BITS, default 5, log2 of the number of sets.
REQ-004 SHALL have parameter OFFSET_BITS, default 3, log2 of words per line; LINE_WIDTH = DATA_WIDTH*2**OFFSET_BITS.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have these request ports: req_valid input 1; req_write input 1; req_addr input ADDRESS_WIDTH; req_wdata input DATA_WIDTH; req_ready output 1.
REQ-007 SHALL have these response ports: resp_valid output 1; resp_rdata output DATA_WIDTH.
REQ-008 SHALL have these memory ports: mem_req_valid output 1; mem_req_write output 1; mem_req_addr output ADDRESS_WIDTH, line-aligned with the low OFFSET_BITS at 0; mem_wdata output LINE_WIDTH; mem_req_ready input 1; mem_resp_valid input 1; mem_rdata input LINE_WIDTH.

Function
REQ-009 SHALL be a 2-way set-associative, write-back, write-allocate cache.
REQ-010 SHALL keep, per set, one LRU bit, and per way valid, dirty, a tag of ADDRESS_WIDTH-SET_BITS-OFFSET_BITS bits, and a line.
REQ-011 SHALL accept a request on a cycle with req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
REQ-012 SHALL, on a read hit, assert resp_valid for one cycle on the next cycle, with the addressed word on resp_rdata, and set LRU to the other way.
REQ-013 SHALL, on a write hit, merge req_wdata into the addressed word, set dirty, update LRU, and pulse resp_valid on the next cycle, with resp_rdata equal to the written word.
REQ-014 SHALL, on a miss, choose a victim: an invalid way first, with way 0 preferred when both are invalid; otherwise the LRU way.
REQ-015 SHALL follow these FSM states: IDLE, WB, FILL, WAIT, RESP.
REQ-016 SHALL move IDLE->WB on a miss with a valid and dirty victim, and IDLE->FILL otherwise.
REQ-017 SHALL, in WB, hold mem_req_valid=1, mem_req_write=1, the victim line address, and the victim data stable until mem_req_ready, then go to FILL.
REQ-018 SHALL, in FILL, hold mem_req_valid=1, mem_req_write=0, and the request line address until mem_req_ready, then go to WAIT.
REQ-019 SHALL, in WAIT, on mem_resp_valid, install mem_rdata into the victim way with valid=1 and the new tag, merging req_wdata and setting dirty=1 if the request is a write, else dirty=0, then go to RESP.
REQ-020 SHALL, in RESP, pulse resp_valid with the word and update LRU, then return to IDLE.
REQ-021 SHALL capture the request (addr, write, wdata) at acceptance and ignore request ports until IDLE.
REQ-022 SHALL give a miss latency from acceptance to resp_valid of: 1 + WB handshake cycles + FILL handshake cycles + WAIT cycles + 1.
REQ-023 SHALL ignore mem_resp_valid outside WAIT.
REQ-024 SHALL keep mem_req_valid at 0 in IDLE, WAIT, and RESP.
REQ-025 SHALL keep resp_rdata stable when resp_valid=0; its value is don't-care.

Reset
REQ-026 SHALL, with rst high at a clock edge, clear all valid, dirty, and LRU bits, and set the state to IDLE.
REQ-027 SHALL, during and after reset, drive req_ready=0 in the reset cycle, and resp_valid=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0.
REQ-028 SHALL, when reset arrives mid-miss, abandon the transaction with no response, discard dirty data, and deassert mem_req_valid the cycle after rst.
REQ-029 SHALL NOT reset the tag and data arrays.

Structure
REQ-030 SHALL define the state enum (IDLE, WB, FILL, WAIT, RESP) and the default parameter constants in package cache_pkg.
REQ-031 SHALL instantiate a sub-module, line_word_sel, for combinational word extract and word merge of a line by offset, used by the hit and fill paths.

Verification
REQ-032 SHALL cover a cold read miss: after reset, read 0x40; memory returns line words 0..7 = 0xA0..0xA7 -> FILL issued at line 0x40, no WB, resp_rdata=0xA0, then read 0x43 hits with resp_rdata=0xA3 one cycle after acceptance.
REQ-033 SHALL cover write-hit then eviction: write 0xDEAD to 0x41 with a hit, then two misses in the same set at tags differing from it -> the second miss issues WB at line 0x40 with word 1 = 0xDEAD before FILL.
REQ-034 SHALL cover LRU: fill both ways of set 0, touch way 0, miss in set 0 -> way 1 is replaced, and a subsequent read of the way-0 address hits.
REQ-035 SHALL cover backpressure: hold mem_req_ready=0 for 5 cycles in FILL -> mem_req_valid, mem_req_addr, and mem_req_write stay stable, req_ready=0, and no resp_valid.
REQ-036 SHALL cover a write miss: write 0x1234 to 0x85 on a clean miss -> FILL at 0x80, the installed line has word 5 = 0x1234 and dirty=1, resp_valid once.
REQ-037 SHALL cover reset in WAIT: assert rst while in WAIT, then pulse mem_resp_valid -> no resp_valid, state IDLE, and a re-read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache: controller states
// and the default geometry constants.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        WAIT,
        RESP
    } state_t;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 30;
    localparam int DEFAULT_SET_BITS      = 5;
    localparam int DEFAULT_OFFSET_BITS   = 3;

endpackage

// File: rtl/line_word_sel.sv
// Combinational helper: extracts one word from a cache line by offset and
// produces a copy of the line with that word replaced by wdata.
module line_word_sel
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
    input  logic [DATA_WIDTH*(2**OFFSET_BITS)-1:0] line,
    input  logic [OFFSET_BITS-1:0]                 offset,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    output logic [DATA_WIDTH-1:0]                  word,
    output logic [DATA_WIDTH*(2**OFFSET_BITS)-1:0] merged
);

    // Word extract and word merge at the same offset.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // conditional or partial update, otherwise a latch is inferred.
        word   = line[int'(offset)*DATA_WIDTH +: DATA_WIDTH];
        merged = line;
        merged[int'(offset)*DATA_WIDTH +: DATA_WIDTH] = wdata;
    end

endmodule

// File: rtl/assoc_cache.sv
// 2-way set-associative, write-back, write-allocate cache with one LRU bit
// per set and a single outstanding miss towards a line-wide memory port.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int SET_BITS      = DEFAULT_SET_BITS,
    parameter int OFFSET_BITS   = DEFAULT_OFFSET_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    input  logic                                   req_write,
    input  logic [ADDRESS_WIDTH-1:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    output logic                                   req_ready,
    output logic                                   resp_valid,
    output logic [DATA_WIDTH-1:0]                  resp_rdata,
    output logic                                   mem_req_valid,
    output logic                                   mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]               mem_req_addr,
    output logic [DATA_WIDTH*(2**OFFSET_BITS)-1:0] mem_wdata,
    input  logic                                   mem_req_ready,
    input  logic                                   mem_resp_valid,
    input  logic [DATA_WIDTH*(2**OFFSET_BITS)-1:0] mem_rdata
);

    localparam int LINE_WIDTH = DATA_WIDTH * (2**OFFSET_BITS);
    localparam int TAG_BITS   = ADDRESS_WIDTH - SET_BITS - OFFSET_BITS;
    localparam int SETS       = 2**SET_BITS;

    state_t state, state_nx;

    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       dirty_q [2];
    logic [SETS-1:0]       lru_q;       // way to replace next in each set
    logic [TAG_BITS-1:0]   tag_mem  [2][SETS];
    logic [LINE_WIDTH-1:0] data_mem [2][SETS];

    // Captured request and the victim chosen at acceptance
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     victim_q;

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic [SET_BITS-1:0]    req_idx, r_idx;
    logic [TAG_BITS-1:0]    req_tag, r_tag;
    logic [OFFSET_BITS-1:0] req_off, r_off;

    assign req_idx = req_addr[OFFSET_BITS +: SET_BITS];
    assign req_tag = req_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
    assign req_off = req_addr[OFFSET_BITS-1:0];
    assign r_idx   = r_addr[OFFSET_BITS +: SET_BITS];
    assign r_tag   = r_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
    assign r_off   = r_addr[OFFSET_BITS-1:0];

    logic                  hit0, hit1, hit, hit_way;
    logic                  victim_way, needs_wb, accept;
    logic [LINE_WIDTH-1:0] hit_line, hit_merged, fill_merged;
    logic [DATA_WIDTH-1:0] hit_word, fill_word;

    assign hit0     = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign hit1     = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;
    assign hit_line = data_mem[hit_way][req_idx];
    assign accept   = req_valid && req_ready;

    // Victim: an invalid way (way 0 first), otherwise the LRU way
    assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign needs_wb   = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];

    line_word_sel #(.DATA_WIDTH(DATA_WIDTH), .OFFSET_BITS(OFFSET_BITS)) u_hit_sel (
        .line   (hit_line),
        .offset (req_off),
        .wdata  (req_wdata),
        .word   (hit_word),
        .merged (hit_merged)
    );

    line_word_sel #(.DATA_WIDTH(DATA_WIDTH), .OFFSET_BITS(OFFSET_BITS)) u_fill_sel (
        .line   (mem_rdata),
        .offset (r_off),
        .wdata  (r_wdata),
        .word   (fill_word),
        .merged (fill_merged)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && !hit) state_nx = needs_wb ? WB : FILL;
            WB:   if (mem_req_ready)  state_nx = FILL;
            FILL: if (mem_req_ready)  state_nx = WAIT;
            WAIT: if (mem_resp_valid) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs; everything is forced quiet while reset is asserted
    always_comb begin
        req_ready     = !rst && (state == IDLE);
        resp_valid    = !rst && resp_valid_q;
        resp_rdata    = resp_rdata_q;
        mem_req_valid = !rst && ((state == WB) || (state == FILL));
        mem_req_write = !rst && (state == WB);
        mem_req_addr  = '0;
        mem_wdata     = '0;
        if (!rst && state == WB) begin
            mem_req_addr = {tag_mem[victim_q][r_idx], r_idx, {OFFSET_BITS{1'b0}}};
            mem_wdata    = data_mem[victim_q][r_idx];
        end else if (!rst && state == FILL) begin
            mem_req_addr = {r_tag, r_idx, {OFFSET_BITS{1'b0}}};
        end
    end

    // Control state: valid/dirty/LRU, request capture and the response register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            victim_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    r_addr   <= req_addr;
                    r_write  <= req_write;
                    r_wdata  <= req_wdata;
                    victim_q <= victim_way;
                    if (hit) begin
                        resp_valid_q   <= 1'b1;
                        resp_rdata_q   <= req_write ? req_wdata : hit_word;
                        lru_q[req_idx] <= ~hit_way;
                        if (req_write) dirty_q[hit_way][req_idx] <= 1'b1;
                    end
                end
                WAIT: if (mem_resp_valid) begin
                    valid_q[victim_q][r_idx] <= 1'b1;
                    dirty_q[victim_q][r_idx] <= r_write;
                    resp_valid_q             <= 1'b1;
                    resp_rdata_q             <= r_write ? r_wdata : fill_word;
                end
                RESP: lru_q[r_idx] <= ~victim_q;
                default: ;
            endcase
        end
    end

    // Tag and data arrays: write-hit merge and line install on fill
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; cleared valid bits make their
        // contents unreachable, and a reset-free array maps onto plain RAM.
        if (!rst && state == IDLE && accept && hit && req_write)
            data_mem[hit_way][req_idx] <= hit_merged;
        if (!rst && state == WAIT && mem_resp_valid) begin
            data_mem[victim_q][r_idx] <= r_write ? fill_merged : mem_rdata;
            tag_mem[victim_q][r_idx]  <= r_tag;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: a memory agent, a line-recency cache
// model, and one compare process checking memory traffic and responses.
module tb_assoc_cache;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int LW = 256;
    localparam int K_NONE = 0, K_WB = 1, K_FILL = 2, K_RESP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write, req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;

    assoc_cache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backing store content: untouched lines hold word address + 0x60
    function automatic logic [LW-1:0] default_line(input int la);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'(la + i + 32'h60);
        return l;
    endfunction

    // ---------------- memory agent (driven by DUT traffic) ----------------
    logic [LW-1:0] dut_mem [int];
    int  wb_stall = 0, fill_stall = 0, resp_wait = 0;
    bit  in_req = 0, pend = 0, resp_pulsed = 0;
    int  stall_cnt = 0, pend_cnt = 0, pend_addr = 0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (rst) in_req = 0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = dut_mem.exists(pend_addr) ? dut_mem[pend_addr] : default_line(pend_addr);
                    pend           = 0;
                    resp_pulsed    = 1;
                end else pend_cnt--;
            end
            if (mem_req_valid && !rst) begin
                if (!in_req) begin
                    in_req    = 1;
                    stall_cnt = mem_req_write ? wb_stall : fill_stall;
                end
                if (stall_cnt > 0) stall_cnt--;
                else begin
                    mem_req_ready = 1'b1;
                    in_req        = 0;
                    if (mem_req_write) dut_mem[int'(mem_req_addr)] = mem_wdata;
                    else begin
                        pend      = 1;
                        pend_cnt  = resp_wait;
                        pend_addr = int'(mem_req_addr);
                    end
                end
            end
        end
    end

    // ---------------- reference model: per-set recency of resident lines ----------------
    logic [LW-1:0] ref_mem    [int];
    logic [LW-1:0] cache_data [int];
    bit            cache_dirty[int];
    int            mru_line [32];
    int            lru_line [32];

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            mru_line[s] = -1;
            lru_line[s] = -1;
        end
        cache_data.delete();
        cache_dirty.delete();
    endtask

    task automatic model_access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                output bit hit, output bit wb, output logic [AW-1:0] wba,
                                output logic [LW-1:0] wbl, output logic [DW-1:0] rd);
        int la, s, off, v;
        logic [LW-1:0] line;
        la  = int'({a[AW-1:3], 3'b000});
        s   = int'(a[7:3]);
        off = int'(a[2:0]);
        hit = (mru_line[s] == la) || (lru_line[s] == la);
        wb  = 0;
        wba = '0;
        wbl = '0;
        if (hit) begin
            if (lru_line[s] == la) begin
                lru_line[s] = mru_line[s];
                mru_line[s] = la;
            end
        end else begin
            if (lru_line[s] != -1) begin
                v = lru_line[s];
                if (cache_dirty[v]) begin
                    wb         = 1;
                    wba        = AW'(v);
                    wbl        = cache_data[v];
                    ref_mem[v] = wbl;
                end
                cache_data.delete(v);
                cache_dirty.delete(v);
            end
            lru_line[s]     = mru_line[s];
            mru_line[s]     = la;
            cache_data[la]  = ref_mem.exists(la) ? ref_mem[la] : default_line(la);
            cache_dirty[la] = 0;
        end
        line = cache_data[la];
        if (w) begin
            line[off*32 +: 32] = wd;
            cache_data[la]     = line;
            cache_dirty[la]    = 1;
        end
        rd = line[off*32 +: 32];
    endtask

    // ---------------- expectations and compare process ----------------
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        logic [DW-1:0] word;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];

    bit            hold_pend = 0, have_prev = 0;
    logic [AW-1:0] hold_addr;
    logic          hold_write;
    logic [LW-1:0] hold_wdata;
    logic [DW-1:0] prev_rdata;

    initial begin
        exp_t e;
        int   front;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold_pend = 0;
                have_prev = 0;
            end else begin
                if (hold_pend) begin
                    check("mem_hold_valid", mem_req_valid, 1'b1);
                    check("mem_hold_addr",  mem_req_addr,  hold_addr);
                    check("mem_hold_write", mem_req_write, hold_write);
                    check("mem_hold_wdata", mem_wdata,     hold_wdata);
                    hold_pend = 0;
                end
                if (mem_req_valid) begin
                    check("req_ready_busy", req_ready, 1'b0);
                    if (!mem_req_ready) begin
                        hold_pend  = 1;
                        hold_addr  = mem_req_addr;
                        hold_write = mem_req_write;
                        hold_wdata = mem_wdata;
                    end else begin
                        front = (exp_q.size() != 0) ? exp_q[0].kind : K_NONE;
                        check("mem_kind", mem_req_write ? K_WB : K_FILL, front);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("mem_addr", mem_req_addr, e.addr);
                            if (e.kind == K_WB) check("wb_line", mem_wdata, e.line);
                        end
                    end
                end
                if (resp_valid) begin
                    front = (exp_q.size() != 0) ? exp_q[0].kind : K_NONE;
                    check("resp_kind", K_RESP, front);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("resp_rdata",   resp_rdata,    e.word);
                        check("resp_latency", cyc - e.acc,   e.lat);
                    end
                end else if (have_prev) begin
                    check("rdata_stable", resp_rdata, prev_rdata);
                end
                prev_rdata = resp_rdata;
                have_prev  = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input string name, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit exp_hit, input bit exp_wb,
                          input logic [DW-1:0] exp_rd,
                          output logic [AW-1:0] wba, output logic [LW-1:0] wbl);
        bit            hit, wb;
        logic [DW-1:0] rd;
        exp_t          e;
        int            n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, req_ready, 1'b1);
        model_access(w, a, wd, hit, wb, wba, wbl, rd);
        check({name, "_model_hit"},   hit, exp_hit);
        check({name, "_model_wb"},    wb,  exp_wb);
        check({name, "_model_rdata"}, rd,  exp_rd);
        if (wb) begin
            e.kind = K_WB; e.addr = wba; e.line = wbl;
            exp_q.push_back(e);
        end
        if (!hit) begin
            e.kind = K_FILL; e.addr = {a[AW-1:3], 3'b000}; e.line = '0;
            exp_q.push_back(e);
        end
        e.kind = K_RESP;
        e.word = rd;
        e.acc  = cyc;
        // Inclusive miss latency 1 + WB + FILL + WAIT + 1 cycles, so the
        // distance from the acceptance cycle is one less.
        e.lat  = hit ? 1 : ((wb ? wb_stall + 1 : 0) + (fill_stall + 1) + (resp_wait + 1) + 1);
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = 32'hBAD0_BAD0;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [AW-1:0] wba;
        logic [LW-1:0] wbl;
        int n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready",     req_ready,     1'b0);
        check("rst_resp_valid",    resp_valid,    1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_write", mem_req_write, 1'b0);
        check("rst_mem_req_addr",  mem_req_addr,  '0);
        check("rst_mem_wdata",     mem_wdata,     '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);

        // Cold read miss, then a hit in the same line
        do_req("cold_miss", 0, 30'h040, '0, 0, 0, 32'hA0, wba, wbl);
        do_req("cold_hit",  0, 30'h043, '0, 1, 0, 32'hA3, wba, wbl);

        // Write hit, then two misses in set 8 force the dirty line out
        do_req("wr_hit",    1, 30'h041, 32'hDEAD, 1, 0, 32'hDEAD, wba, wbl);
        do_req("set8_t1",   0, 30'h140, '0, 0, 0, 32'h1A0, wba, wbl);
        do_req("set8_t2",   0, 30'h240, '0, 0, 1, 32'h2A0, wba, wbl);
        check("evict_wb_addr",  wba,        30'h040);
        check("evict_wb_word1", wbl[63:32], 32'hDEAD);
        do_req("reread_wb", 0, 30'h041, '0, 0, 0, 32'hDEAD, wba, wbl);

        // LRU in set 0
        do_req("lru_a",       0, 30'h000, '0, 0, 0, 32'h060, wba, wbl);
        do_req("lru_b",       0, 30'h100, '0, 0, 0, 32'h160, wba, wbl);
        do_req("lru_touch_a", 0, 30'h000, '0, 1, 0, 32'h060, wba, wbl);
        do_req("lru_c",       0, 30'h200, '0, 0, 0, 32'h260, wba, wbl);
        do_req("lru_a_hit",   0, 30'h000, '0, 1, 0, 32'h060, wba, wbl);
        do_req("lru_b_miss",  0, 30'h100, '0, 0, 0, 32'h160, wba, wbl);

        // Memory backpressure during FILL
        fill_stall = 5;
        do_req("bp_fill", 0, 30'h058, '0, 0, 0, 32'h0B8, wba, wbl);
        fill_stall = 0;

        // Write miss, verified through a hit and a later write-back
        do_req("wr_miss",     1, 30'h085, 32'h1234, 0, 0, 32'h1234, wba, wbl);
        do_req("wr_miss_hit", 0, 30'h085, '0, 1, 0, 32'h1234, wba, wbl);
        resp_wait = 2;
        do_req("set16_t1",    0, 30'h180, '0, 0, 0, 32'h1E0, wba, wbl);
        wb_stall = 2;
        do_req("set16_t2",    0, 30'h280, '0, 0, 1, 32'h2E0, wba, wbl);
        check("wm_wb_addr",  wba,          30'h080);
        check("wm_wb_word5", wbl[191:160], 32'h1234);
        check("wm_wb_word0", wbl[31:0],    32'h0E0);
        wb_stall  = 0;
        resp_wait = 0;

        // Reset while waiting for the fill response
        resp_wait = 4;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        begin
            exp_t e;
            e.kind = K_FILL; e.addr = 30'h3C0; e.line = '0; e.word = '0; e.lat = 0; e.acc = 0;
            exp_q.push_back(e);
        end
        resp_pulsed = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 30'h3C0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rw_fill_done", exp_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_mem_valid_after_rst", mem_req_valid, 1'b0);
        check("rw_ready_after_rst",     req_ready,     1'b1);
        check("rw_resp_after_rst",      resp_valid,    1'b0);
        repeat (6) @(negedge clk);
        check("rw_stale_resp_pulsed", resp_pulsed, 1'b1);
        check("rw_idle_after_stale",  req_ready,   1'b1);
        model_reset();
        resp_wait = 0;
        do_req("rw_reread", 0, 30'h3C0, '0, 0, 0, 32'h420, wba, wbl);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
